// File: rtl/simon_pkg.sv
// Shared definitions for the Simon Says engine: FSM state encoding and LFSR constants.
package simon_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned LFSR_W  = 8;

    // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3)
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_GEN      = 3'd1,
        ST_SHOW_ON  = 3'd2,
        ST_SHOW_OFF = 3'd3,
        ST_WAIT     = 3'd4,
        ST_RELEASE  = 3'd5,
        ST_WIN      = 3'd6,
        ST_LOSE     = 3'd7
    } state_t;

endpackage

// File: rtl/simon_lfsr.sv
// 8-bit Fibonacci LFSR with zero-safe seed load and shift enable.
module simon_lfsr
    import simon_pkg::*;
#(
    parameter int unsigned OUT_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [LFSR_W-1:0] seed,
    output logic [OUT_W-1:0]  value
);

    logic [LFSR_W-1:0] lfsr;

    // Load substitutes 0 with 1 so the register never locks up at all-zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_W'(1);
        end else if (load) begin
            lfsr <= (seed == '0) ? LFSR_W'(1) : seed;
        end else if (shift) begin
            lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    assign value = lfsr[OUT_W-1:0];

endmodule

// File: rtl/simon_core.sv
// Simon Says game engine: sequence generation, LED playback, press checking, scoring.
module simon_core
    import simon_pkg::*;
#(
    parameter int unsigned NUM_COLOURS    = 4,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned HOLD_CYCLES    = 10,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [7:0]                   seed,
    input  logic [NUM_COLOURS-1:0]       btn,
    output logic [NUM_COLOURS-1:0]       led,
    output logic [STATE_W-1:0]           state_dbg,
    output logic [$clog2(MAX_LEN+1)-1:0] score,
    output logic                         win,
    output logic                         lose
);

    localparam int unsigned CW      = $clog2(NUM_COLOURS);
    localparam int unsigned LW      = $clog2(MAX_LEN + 1);
    localparam int unsigned IW      = $clog2(MAX_LEN);
    localparam int unsigned HG_MAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX = (HG_MAX > TIMEOUT_CYCLES) ? HG_MAX : TIMEOUT_CYCLES;
    localparam int unsigned CNTW    = $clog2(CNT_MAX + 1);

    state_t                 state, state_d;
    logic [IW-1:0]          idx, idx_d;
    logic [LW-1:0]          round, round_d;
    logic [LW-1:0]          score_d;
    logic [CNTW-1:0]        cnt, cnt_d;
    logic [NUM_COLOURS-1:0] led_d;
    logic [NUM_COLOURS-1:0] target;
    logic                   start_q;
    logic                   start_edge;
    logic                   more;
    logic                   lfsr_load;
    logic [CW-1:0]          colour;
    logic [CW-1:0]          seq [MAX_LEN];

    simon_lfsr #(
        .OUT_W (CW)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .shift (state == ST_GEN),
        .seed  (seed),
        .value (colour)
    );

    assign start_edge = start && !start_q;
    assign target     = NUM_COLOURS'(1) << seq[idx];
    assign more       = LW'(idx) < (round - LW'(1));
    assign state_dbg  = state;

    // Registered copy of start for rising-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start;
        end
    end

    // Sequence storage, filled one entry per GEN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(MAX_LEN); i++) begin
                seq[i] <= '0;
            end
        end else if (state == ST_GEN) begin
            seq[idx] <= colour;
        end
    end

    // FSM and datapath registers, including registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
            round <= LW'(1);
            cnt   <= '0;
            score <= '0;
            led   <= '0;
            win   <= 1'b0;
            lose  <= 1'b0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
            round <= round_d;
            cnt   <= cnt_d;
            score <= score_d;
            led   <= led_d;
            win   <= (state_d == ST_WIN);
            lose  <= (state_d == ST_LOSE);
        end
    end

    // Next-state, counters and next LED pattern
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        round_d   = round;
        cnt_d     = cnt;
        score_d   = score;
        lfsr_load = 1'b0;

        case (state)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (start_edge) begin
                    lfsr_load = 1'b1;
                    state_d   = ST_GEN;
                    idx_d     = '0;
                    round_d   = LW'(1);
                    score_d   = '0;
                    cnt_d     = '0;
                end
            end
            ST_GEN: begin
                if (idx == IW'(MAX_LEN - 1)) begin
                    state_d = ST_SHOW_ON;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else begin
                    idx_d = idx + IW'(1);
                end
            end
            ST_SHOW_ON: begin
                if (cnt == CNTW'(HOLD_CYCLES - 1)) begin
                    state_d = ST_SHOW_OFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNTW'(1);
                end
            end
            ST_SHOW_OFF: begin
                if (cnt == CNTW'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (more) begin
                        idx_d   = idx + IW'(1);
                        state_d = ST_SHOW_ON;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_WAIT;
                    end
                end else begin
                    cnt_d = cnt + CNTW'(1);
                end
            end
            ST_WAIT: begin
                if (btn != '0) begin
                    state_d = (btn == target) ? ST_RELEASE : ST_LOSE;
                end else if (TIMEOUT_CYCLES > 0) begin
                    if (cnt == CNTW'(TIMEOUT_CYCLES)) begin
                        state_d = ST_LOSE;
                    end else begin
                        cnt_d = cnt + CNTW'(1);
                    end
                end
            end
            ST_RELEASE: begin
                if (btn == '0) begin
                    if (more) begin
                        idx_d   = idx + IW'(1);
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end else if (round == LW'(MAX_LEN)) begin
                        score_d = LW'(MAX_LEN);
                        state_d = ST_WIN;
                    end else begin
                        score_d = round;
                        round_d = round + LW'(1);
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_SHOW_ON;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        led_d = (state_d == ST_SHOW_ON) ? (NUM_COLOURS'(1) << seq[idx_d]) : '0;
    end

endmodule

// File: tb/tb_simon_core.sv
// Directed-plus-random bench for simon_core against a behavioural game model.
module tb_simon_core;

    localparam int unsigned NC   = 4;
    localparam int unsigned ML   = 4;
    localparam int unsigned HOLD = 3;
    localparam int unsigned GAP  = 2;
    localparam int unsigned TO   = 20;
    localparam int unsigned LW   = $clog2(ML + 1);

    localparam int S_IDLE = 0, S_GEN = 1, S_ON = 2, S_OFF = 3;
    localparam int S_WAIT = 4, S_REL = 5, S_WIN = 6, S_LOSE = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    seed = 8'h00;
    logic [NC-1:0] btn = '0;
    logic [NC-1:0] led;
    logic [2:0]    state_dbg;
    logic [LW-1:0] score;
    logic          win, lose;

    logic          start0 = 1'b0;
    logic [7:0]    seed0 = 8'h00;
    logic [NC-1:0] btn0 = '0;
    logic [NC-1:0] led0;
    logic [2:0]    state0;
    logic [LW-1:0] score0;
    logic          win0, lose0;

    int n_cmp  = 0;
    int n_fail = 0;
    int unsigned exp_seq [ML];

    always #5 clk = ~clk;

    simon_core #(
        .NUM_COLOURS(NC), .MAX_LEN(ML), .HOLD_CYCLES(HOLD),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .btn(btn),
        .led(led), .state_dbg(state_dbg), .score(score), .win(win), .lose(lose)
    );

    simon_core #(
        .NUM_COLOURS(NC), .MAX_LEN(ML), .HOLD_CYCLES(HOLD),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .seed(seed0), .btn(btn0),
        .led(led0), .state_dbg(state0), .score(score0), .win(win0), .lose(lose0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NC-1:0] oh(input int unsigned c);
        return NC'(1) << c;
    endfunction

    // Reference sequence: colour = LFSR value mod NUM_COLOURS, then advance the polynomial
    function automatic void gen_seq(input logic [7:0] s);
        logic [7:0] v;
        v = (s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < int'(ML); i++) begin
            exp_seq[i] = int'(v) % NC;
            v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
        end
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    // Pulse start with seed s; return in the first SHOW_ON cycle
    task automatic start_game(input logic [7:0] s);
        int n;
        gen_seq(s);
        seed  = s;
        start = 1'b1;
        step();
        start = 1'b0;
        check("gen_entry", 32'(state_dbg), S_GEN);
        check("gen_score", 32'(score), 0);
        n = 0;
        while (state_dbg == 3'(S_GEN) && n < 50) begin
            n++;
            step();
        end
        check("gen_len", n, ML);
        check("show_entry", 32'(state_dbg), S_ON);
    endtask

    // Check playback of a round, returning in the first WAIT cycle
    task automatic show_round(input int r);
        for (int i = 0; i < r; i++) begin
            for (int unsigned h = 0; h < HOLD; h++) begin
                check($sformatf("r%0d_i%0d_on_state", r, i), 32'(state_dbg), S_ON);
                check($sformatf("r%0d_i%0d_on_led", r, i), 32'(led), 32'(oh(exp_seq[i])));
                step();
            end
            for (int unsigned g = 0; g < GAP; g++) begin
                check($sformatf("r%0d_i%0d_off_state", r, i), 32'(state_dbg), S_OFF);
                check($sformatf("r%0d_i%0d_off_led", r, i), 32'(led), 0);
                step();
            end
        end
        check($sformatf("r%0d_wait_entry", r), 32'(state_dbg), S_WAIT);
        check($sformatf("r%0d_wait_led", r), 32'(led), 0);
    endtask

    // Correct press after a random pause, held a random time, then released
    task automatic press_ok(input int unsigned col);
        int unsigned d;
        int unsigned hx;
        d  = $urandom_range(0, 4);
        hx = $urandom_range(0, 2);
        for (int unsigned k = 0; k < d; k++) begin
            step();
            check("pause_wait", 32'(state_dbg), S_WAIT);
        end
        btn = oh(col);
        step();
        check("press_release", 32'(state_dbg), S_REL);
        for (int unsigned k = 0; k < hx; k++) begin
            step();
            check("hold_release", 32'(state_dbg), S_REL);
        end
        btn = '0;
        step();
    endtask

    task automatic play_round(input int r);
        show_round(r);
        for (int i = 0; i < r; i++) begin
            press_ok(exp_seq[i]);
            if (i < r - 1) begin
                check($sformatf("r%0d_next_wait", r), 32'(state_dbg), S_WAIT);
            end else if (r == int'(ML)) begin
                check("win_state", 32'(state_dbg), S_WIN);
                check("win_flag", 32'(win), 1);
                check("win_score", 32'(score), ML);
                check("win_led", 32'(led), 0);
                check("win_lose", 32'(lose), 0);
            end else begin
                check($sformatf("r%0d_score", r), 32'(score), r);
                check($sformatf("r%0d_next_show", r), 32'(state_dbg), S_ON);
            end
        end
    endtask

    initial begin
        int n;
        int unsigned a, b;
        logic [NC-1:0] two;

        // Reset values
        step();
        check("rst_state", 32'(state_dbg), S_IDLE);
        check("rst_led", 32'(led), 0);
        check("rst_score", 32'(score), 0);
        check("rst_win", 32'(win), 0);
        check("rst_lose", 32'(lose), 0);
        rst_n = 1'b1;
        step();
        check("idle_hold", 32'(state_dbg), S_IDLE);

        // Full winning game with a random seed
        start_game(8'($urandom_range(1, 255)));
        for (int r = 1; r <= int'(ML); r++) begin
            play_round(r);
        end

        // Zero seed behaves as seed 1; wrong colour on round 2 second press
        start_game(8'h00);
        play_round(1);
        show_round(2);
        press_ok(exp_seq[0]);
        check("wrong_pre_wait", 32'(state_dbg), S_WAIT);
        btn = oh((exp_seq[1] + 32'($urandom_range(1, 3))) % NC);
        step();
        btn = '0;
        check("wrong_state", 32'(state_dbg), S_LOSE);
        check("wrong_lose", 32'(lose), 1);
        check("wrong_score", 32'(score), 1);
        check("wrong_led", 32'(led), 0);
        step();
        check("lose_hold", 32'(state_dbg), S_LOSE);

        // Restart from LOSE; start pulse during SHOW_ON ignored; two buttons lose
        start_game(8'($urandom_range(0, 255)));
        seed  = ~seed;
        start = 1'b1;
        step();
        start = 1'b0;
        check("ign_on2_state", 32'(state_dbg), S_ON);
        check("ign_on2_led", 32'(led), 32'(oh(exp_seq[0])));
        step();
        check("ign_on3_state", 32'(state_dbg), S_ON);
        step();
        check("ign_off_state", 32'(state_dbg), S_OFF);
        step();
        step();
        check("ign_wait", 32'(state_dbg), S_WAIT);
        a = $urandom_range(0, NC - 1);
        b = (a + 32'($urandom_range(1, NC - 1))) % NC;
        two = oh(a) | oh(b);
        btn = two;
        step();
        btn = '0;
        check("two_btn_state", 32'(state_dbg), S_LOSE);
        check("two_btn_lose", 32'(lose), 1);

        // Timeout: LOSE visible TO+1 cycles after WAIT entry
        start_game(8'($urandom_range(0, 255)));
        show_round(1);
        n = 0;
        while (lose == 1'b0 && n < 100) begin
            step();
            n++;
        end
        check("timeout_cycles", n, TO + 1);
        check("timeout_state", 32'(state_dbg), S_LOSE);

        // Asynchronous reset in the middle of SHOW_ON
        start_game(8'($urandom_range(0, 255)));
        step();
        check("pre_rst_led", 32'(led), 32'(oh(exp_seq[0])));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 0);
        check("async_rst_state", 32'(state_dbg), S_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_state", 32'(state_dbg), S_IDLE);
            check("post_rst_led", 32'(led), 0);
            check("post_rst_score", 32'(score), 0);
        end

        // No timeout when TIMEOUT_CYCLES is 0
        seed0  = 8'($urandom_range(0, 255));
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        n = 0;
        while (state0 != 3'(S_WAIT) && n < 200) begin
            step();
            n++;
        end
        check("t0_reach_wait", 32'(state0), S_WAIT);
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            step();
            if (state0 != 3'(S_WAIT)) n++;
        end
        check("t0_cycles_left_wait", n, 0);
        check("t0_lose", 32'(lose0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
